// File: rtl/mem_dbus_master.sv
// mem_dbus_master: MEM-stage data-bus master. Runs one req/ack transaction per
// load/store, stalls the pipeline until the ack arrives, and formats load data
// (big-endian lanes) for the MEM/WB register. HOLD keeps a finished result
// while the pipeline is frozen for another reason, so the op is not re-issued.
module mem_dbus_master #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] mem_aluop,
  input  logic [DW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_reg2,
  input  logic [AW-1:0]  mem_wd,
  input  logic           mem_wreg,
  input  logic [DW-1:0]  mem_wdata,
  input  logic           stall_in,
  input  logic           flush,
  output logic           dbus_req,
  output logic           dbus_we,
  output logic [DW-1:0]  dbus_addr,
  output logic [3:0]     dbus_sel,
  output logic [DW-1:0]  dbus_wdata,
  input  logic           dbus_ack,
  input  logic [DW-1:0]  dbus_rdata,
  output logic           stallreq,
  output logic [AW-1:0]  wb_wd,
  output logic           wb_wreg,
  output logic [DW-1:0]  wb_wdata
);
  localparam logic [OPW-1:0] OP_LB  = OPW'(8'hE0);
  localparam logic [OPW-1:0] OP_LH  = OPW'(8'hE1);
  localparam logic [OPW-1:0] OP_LW  = OPW'(8'hE3);
  localparam logic [OPW-1:0] OP_LBU = OPW'(8'hE4);
  localparam logic [OPW-1:0] OP_LHU = OPW'(8'hE5);
  localparam logic [OPW-1:0] OP_SB  = OPW'(8'hE8);
  localparam logic [OPW-1:0] OP_SH  = OPW'(8'hE9);
  localparam logic [OPW-1:0] OP_SW  = OPW'(8'hEB);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;
  state_t state, state_n;

  logic          is_load, is_store, is_mem, ld_sign;
  logic [1:0]    size;            // 0 byte, 1 half, 2 word
  logic [3:0]    sel_n;
  logic [DW-1:0] wdata_n;

  // Latched at issue so formatting does not depend on the held inputs.
  logic          ld_q, sign_q;
  logic [1:0]    size_q, lane_q;
  logic [DW-1:0] buf_q;

  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] ld_data, result;

  // Decode aluop into access class, size and signedness.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    ld_sign  = 1'b0;
    size     = 2'd2;
    case (mem_aluop)
      OP_LB:  begin is_load  = 1'b1; ld_sign = 1'b1; size = 2'd0; end
      OP_LH:  begin is_load  = 1'b1; ld_sign = 1'b1; size = 2'd1; end
      OP_LW:  begin is_load  = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; size = 2'd0; end
      OP_LHU: begin is_load  = 1'b1; size = 2'd1; end
      OP_SB:  begin is_store = 1'b1; size = 2'd0; end
      OP_SH:  begin is_store = 1'b1; size = 2'd1; end
      OP_SW:  begin is_store = 1'b1; end
      default: ;
    endcase
  end
  assign is_mem = is_load | is_store;

  // Byte lanes and replicated store data; misaligned low bits are simply ignored.
  always_comb begin
    case (size)
      2'd0: begin
        sel_n   = 4'b1000 >> mem_addr[1:0];
        wdata_n = {4{mem_reg2[7:0]}};
      end
      2'd1: begin
        sel_n   = mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_n = {2{mem_reg2[15:0]}};
      end
      default: begin
        sel_n   = 4'b1111;
        wdata_n = mem_reg2;
      end
    endcase
  end

  // Pick the addressed byte/half of the read word and extend it.
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = dbus_rdata[31:24];
      2'd1:    rd_byte = dbus_rdata[23:16];
      2'd2:    rd_byte = dbus_rdata[15:8];
      default: rd_byte = dbus_rdata[7:0];
    endcase
    rd_half = lane_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
    case (size_q)
      2'd0:    ld_data = {{(DW-8){sign_q & rd_byte[7]}}, rd_byte};
      2'd1:    ld_data = {{(DW-16){sign_q & rd_half[15]}}, rd_half};
      default: ld_data = dbus_rdata;
    endcase
  end
  assign result = ld_q ? ld_data : mem_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state: flush always wins and returns to IDLE.
  always_comb begin
    state_n = state;
    if (flush) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (is_mem)    state_n = S_BUSY;
        S_BUSY:  if (dbus_ack)  state_n = stall_in ? S_HOLD : S_IDLE;
        S_HOLD:  if (!stall_in) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Stall request and write-back outputs; everything reads 0 under reset.
  always_comb begin
    stallreq = 1'b0;
    wb_wd    = '0;
    wb_wreg  = 1'b0;
    wb_wdata = '0;
    if (!rst) begin
      wb_wd   = flush ? '0 : mem_wd;
      wb_wreg = mem_wreg & ~flush;
      case (state)
        S_IDLE: begin
          stallreq = is_mem & ~flush;
          wb_wdata = mem_wdata;
        end
        S_BUSY: begin
          stallreq = ~dbus_ack & ~flush;
          wb_wdata = dbus_ack ? result : mem_wdata;
        end
        S_HOLD:  wb_wdata = buf_q;
        default: ;
      endcase
    end
  end

  // Bus registers: load at issue, drop req at ack (buffering the result) or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= '0;
      dbus_wdata <= '0;
      ld_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      buf_q      <= '0;
    end else if (flush) begin
      dbus_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (is_mem) begin
          dbus_req   <= 1'b1;
          dbus_we    <= is_store;
          dbus_addr  <= {mem_addr[DW-1:2], 2'b00};
          dbus_sel   <= sel_n;
          dbus_wdata <= wdata_n;
          ld_q       <= is_load;
          sign_q     <= ld_sign;
          size_q     <= size;
          lane_q     <= mem_addr[1:0];
        end
        S_BUSY: if (dbus_ack) begin
          dbus_req <= 1'b0;
          buf_q    <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_master.sv
// Bench for mem_dbus_master: directed scenarios with literal expectations plus
// a randomized pipeline/bus run, all compared every cycle against a
// transaction-level model of the MEM stage.
module tb_mem_dbus_master;
  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4,
                         LHU = 8'hE5, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr, mem_reg2, mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, stall_in, flush;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic        stallreq;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_dbus_master dut (
    .clk(clk), .rst(rst), .mem_aluop(mem_aluop), .mem_addr(mem_addr),
    .mem_reg2(mem_reg2), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .stall_in(stall_in), .flush(flush),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .stallreq(stallreq), .wb_wd(wb_wd),
    .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules as arithmetic) ----------------
  function automatic bit is_mem_op(input logic [7:0] op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction
  function automatic bit is_store_op(input logic [7:0] op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic int op_bytes(input logic [7:0] op);
    if (op inside {LB, LBU, SB}) return 1;
    if (op inside {LH, LHU, SH}) return 2;
    return 4;
  endfunction
  // Offset of the access within the word, aligned down to the access size.
  function automatic int op_off(input logic [7:0] op, input logic [1:0] a);
    int n = op_bytes(op);
    return int'(a) & ~(n - 1);
  endfunction
  function automatic logic [3:0] lanes(input logic [7:0] op, input logic [1:0] a);
    int n = op_bytes(op);
    int m = ((1 << n) - 1) << (4 - n - op_off(op, a));
    return 4'(m);
  endfunction
  function automatic logic [31:0] store_val(input logic [7:0] op, input logic [31:0] r2);
    int n = op_bytes(op);
    logic [63:0] piece = 64'(r2) & ((64'd1 << (8 * n)) - 1);
    logic [63:0] r = '0;
    for (int i = 0; i < 4 / n; i++) r = r | (piece << (8 * n * i));
    return r[31:0];
  endfunction
  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [1:0] a, input logic [31:0] rd);
    int n = op_bytes(op);
    int sh = 8 * (4 - n - op_off(op, a));
    logic [63:0] mask = (64'd1 << (8 * n)) - 1;
    logic [63:0] v = (64'(rd) >> sh) & mask;
    if ((op == LB || op == LH) && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Model state: an outstanding bus transaction, or a finished result being held.
  bit          m_busy = 1'b0, m_held = 1'b0, m_adv = 1'b1;
  logic [7:0]  m_op = '0;
  logic [1:0]  m_a = '0;
  logic [31:0] m_buf = '0, t_addr = '0, t_wdata = '0;
  logic [3:0]  t_sel = '0;
  logic        t_we = 1'b0;

  typedef struct packed {
    logic        stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        wdata_ok;
  } exp_t;

  function automatic logic [31:0] result_val();
    return is_store_op(m_op) ? mem_wdata : load_val(m_op, m_a, dbus_rdata);
  endfunction

  function automatic exp_t calc();
    exp_t e;
    e = '0;
    if (rst) begin
      e.wdata_ok = 1'b1;
      return e;
    end
    e.wd   = flush ? 5'd0 : mem_wd;
    e.wreg = mem_wreg && !flush;
    if (m_busy) begin
      e.stall = !dbus_ack && !flush;
      if (dbus_ack && !flush) begin
        e.wdata_ok = 1'b1;
        e.wdata    = result_val();
      end
    end else if (m_held) begin
      e.wdata_ok = 1'b1;
      e.wdata    = m_buf;
    end else begin
      e.stall = is_mem_op(mem_aluop) && !flush;
      if (!is_mem_op(mem_aluop)) begin
        e.wdata_ok = 1'b1;
        e.wdata    = mem_wdata;
      end
    end
    return e;
  endfunction

  // Advance the model at each edge; m_adv says whether the pipeline moved on.
  always @(posedge clk) begin : mdl
    exp_t e;
    e = calc();
    m_adv <= rst || flush || (!e.stall && !stall_in);
    if (rst || flush) begin
      m_busy <= 1'b0;
      m_held <= 1'b0;
    end else if (m_busy) begin
      if (dbus_ack) begin
        m_busy <= 1'b0;
        m_held <= stall_in;
        m_buf  <= result_val();
      end
    end else if (m_held) begin
      if (!stall_in) m_held <= 1'b0;
    end else if (is_mem_op(mem_aluop)) begin
      m_busy  <= 1'b1;
      m_op    <= mem_aluop;
      m_a     <= mem_addr[1:0];
      t_addr  <= mem_addr & ~32'h3;
      t_sel   <= lanes(mem_aluop, mem_addr[1:0]);
      t_we    <= is_store_op(mem_aluop);
      t_wdata <= store_val(mem_aluop, mem_reg2);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    exp_t e;
    e = calc();
    chk("req", 32'(dbus_req), 32'(m_busy));
    if (m_busy) begin
      chk("bus_addr", dbus_addr, t_addr);
      chk("bus_sel", 32'(dbus_sel), 32'(t_sel));
      chk("bus_we", 32'(dbus_we), 32'(t_we));
      chk("bus_wdata", dbus_wdata, t_wdata);
    end
    chk("stallreq", 32'(stallreq), 32'(e.stall));
    chk("wb_wd", 32'(wb_wd), 32'(e.wd));
    chk("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
    if (e.wdata_ok) chk("wb_wdata", wb_wdata, e.wdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic [31:0] wd);
    mem_aluop = op; mem_addr = addr; mem_reg2 = r2; mem_wdata = wd;
    mem_wd = 5'd7; mem_wreg = 1'b1;
  endtask

  // One memory op: issue, 'waits' cycles without ack, then ack. Captures the bus
  // in the ack cycle, the wb data, and how many cycles stallreq was high.
  task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input int waits, input logic [31:0] rdata,
                         output logic [31:0] o_addr, output logic [3:0] o_sel, output logic o_we,
                         output logic [31:0] o_wdata, output logic [31:0] o_wb, output int o_stalls);
    o_stalls = 0;
    set_op(op, addr, r2, 32'hC0DE0000);
    stall_in = 1'b0; flush = 1'b0; dbus_ack = 1'b0;
    @(negedge clk);
    if (stallreq) o_stalls++;
    for (int i = 0; i <= waits; i++) begin
      tick();
      dbus_ack   = (i == waits);
      dbus_rdata = (i == waits) ? rdata : 32'h0BADF00D;
      @(negedge clk);
      if (stallreq) o_stalls++;
    end
    o_addr = dbus_addr; o_sel = dbus_sel; o_we = dbus_we; o_wdata = dbus_wdata; o_wb = wb_wdata;
    tick();
    dbus_ack = 1'b0;
    set_op(8'h25, 32'h0, 32'h0, 32'h5);
  endtask

  logic [7:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    logic [31:0] a, wd, wb;
    logic [3:0]  s;
    logic        we;
    int          st;

    rst = 1'b1; flush = 1'b0; stall_in = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    set_op(8'h00, 32'h0, 32'h0, 32'h55);

    // Model pinned to hand-computed values.
    chk("model_lb", load_val(LB, 2'd3, 32'h123456F0), 32'hFFFFFFF0);
    chk("model_sh", store_val(SH, 32'hAABBCCDD), 32'hCCDDCCDD);
    chk("model_sel_sb", 32'(lanes(SB, 2'd1)), 32'h4);

    tick(); tick();
    @(negedge clk);
    chk("rst_req", 32'(dbus_req), 0);
    chk("rst_stall", 32'(stallreq), 0);
    chk("rst_wd", 32'(wb_wd), 0);
    chk("rst_wreg", 32'(wb_wreg), 0);
    chk("rst_wdata", wb_wdata, 0);
    tick();
    rst = 1'b0;

    // LW with three wait cycles, then a non-memory op.
    mem_txn(LW, 32'h100, 32'h0, 3, 32'hDEADBEEF, a, s, we, wd, wb, st);
    chk("lw_addr", a, 32'h100);
    chk("lw_sel", 32'(s), 32'hF);
    chk("lw_we", 32'(we), 0);
    chk("lw_wb", wb, 32'hDEADBEEF);
    chk("lw_stalls", st, 4);
    @(negedge clk);
    chk("lw_req_after", 32'(dbus_req), 0);
    chk("alu_stall", 32'(stallreq), 0);
    chk("alu_wdata", wb_wdata, 32'h5);

    // Byte/half loads, minimum latency.
    mem_txn(LB, 32'h103, 32'h0, 0, 32'h123456F0, a, s, we, wd, wb, st);
    chk("lb_sel", 32'(s), 32'h1);
    chk("lb_wb", wb, 32'hFFFFFFF0);
    chk("lb_stalls", st, 1);
    mem_txn(LBU, 32'h103, 32'h0, 0, 32'h123456F0, a, s, we, wd, wb, st);
    chk("lbu_wb", wb, 32'h000000F0);
    mem_txn(LH, 32'h102, 32'h0, 1, 32'h12348001, a, s, we, wd, wb, st);
    chk("lh_sel", 32'(s), 32'h3);
    chk("lh_wb", wb, 32'hFFFF8001);

    // Stores.
    mem_txn(SB, 32'h201, 32'hAABBCCDD, 1, 32'h0, a, s, we, wd, wb, st);
    chk("sb_addr", a, 32'h200);
    chk("sb_sel", 32'(s), 32'h4);
    chk("sb_wdata", wd, 32'hDDDDDDDD);
    chk("sb_we", 32'(we), 1);
    chk("sb_wb", wb, 32'hC0DE0000);
    mem_txn(SH, 32'h202, 32'hAABBCCDD, 0, 32'h0, a, s, we, wd, wb, st);
    chk("sh_sel", 32'(s), 32'h3);
    chk("sh_wdata", wd, 32'hCCDDCCDD);

    // Ack while the pipeline is held: result kept, no re-issue.
    set_op(LW, 32'h40, 32'h0, 32'h0);
    @(negedge clk);
    chk("hold_issue_stall", 32'(stallreq), 1);
    tick(); dbus_ack = 1'b1; dbus_rdata = 32'h11223344; stall_in = 1'b1;
    @(negedge clk);
    chk("hold_ack_wb", wb_wdata, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      tick();
      dbus_ack = (i == 0); dbus_rdata = 32'hFFFF0000; stall_in = (i < 2);
      @(negedge clk);
      chk("hold_req", 32'(dbus_req), 0);
      chk("hold_stall", 32'(stallreq), 0);
      chk("hold_wb", wb_wdata, 32'h11223344);
    end
    tick(); dbus_ack = 1'b0; stall_in = 1'b0;
    set_op(SW, 32'h300, 32'h13579BDF, 32'h0);
    @(negedge clk);
    chk("after_hold_stall", 32'(stallreq), 1);
    chk("after_hold_req", 32'(dbus_req), 0);
    tick();
    @(negedge clk);
    chk("sw_req", 32'(dbus_req), 1);
    chk("sw_wdata", dbus_wdata, 32'h13579BDF);
    tick(); dbus_ack = 1'b1;
    @(negedge clk);
    chk("sw_ack_stall", 32'(stallreq), 0);
    tick(); dbus_ack = 1'b0; set_op(8'h25, 32'h0, 32'h0, 32'h5);

    // Flush in the second BUSY cycle, then a late ack.
    set_op(LW, 32'h80, 32'h0, 32'h0);
    tick();
    tick(); flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stallreq), 0);
    chk("flush_wreg", 32'(wb_wreg), 0);
    chk("flush_wd", 32'(wb_wd), 0);
    tick(); flush = 1'b0; dbus_ack = 1'b1; set_op(8'h25, 32'h0, 32'h0, 32'h5);
    @(negedge clk);
    chk("flush_req_next", 32'(dbus_req), 0);
    chk("late_ack_stall", 32'(stallreq), 0);
    chk("late_ack_wb", wb_wdata, 32'h5);
    tick(); dbus_ack = 1'b0;
    mem_txn(LBU, 32'h81, 32'h0, 1, 32'h00AB0000, a, s, we, wd, wb, st);
    chk("post_flush_sel", 32'(s), 32'h4);
    chk("post_flush_wb", wb, 32'h000000AB);

    // Reset in the middle of a transaction.
    set_op(LW, 32'hC0, 32'h0, 32'h0);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("rstb_stall", 32'(stallreq), 0);
    chk("rstb_wreg", 32'(wb_wreg), 0);
    tick();
    @(negedge clk);
    chk("rstb_req", 32'(dbus_req), 0);
    chk("rstb_sel", 32'(dbus_sel), 0);
    chk("rstb_addr", dbus_addr, 0);
    tick(); rst = 1'b0; dbus_ack = 1'b1; set_op(8'h25, 32'h0, 32'h0, 32'h5);
    @(negedge clk);
    chk("rstb_late_ack_req", 32'(dbus_req), 0);

    // Randomized pipeline: instructions only change when the stage advances.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_adv) begin
        mem_aluop = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 7)] : 8'($urandom);
        mem_addr  = $urandom;
        mem_reg2  = $urandom;
        mem_wdata = $urandom;
        mem_wd    = 5'($urandom);
        mem_wreg  = 1'($urandom);
      end
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      stall_in   = ($urandom_range(0, 3) == 0);
      dbus_ack   = ($urandom_range(0, 2) == 0);
      dbus_rdata = $urandom;
    end
    tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_dbus_master.md
Name: mem_dbus_master

Overview:
- Memory-access stage logic. It consumes the EX/MEM pipeline register outputs: aluop, memory address, store data (reg2), and the write-back triple.
- For load/store ops it runs one transaction on the shared data bus (req/ack handshake) and raises a stall request until the bus acknowledges.
- It produces the write-back triple for the MEM/WB register. Load data is byte-selected and sign- or zero-extended. Big-endian MIPS byte order.

Parameters:
- DW, 32, data/register width (RegBus).
- AW, 5, destination register address width (RegAddrBus).
- OPW, 8, aluop width (AluOpBus).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_aluop  in  OPW  operation. LB=8'hE0, LH=8'hE1, LW=8'hE3, LBU=8'hE4, LHU=8'hE5, SB=8'hE8, SH=8'hE9, SW=8'hEB; any other value is a non-memory op.
- mem_addr  in  DW  effective byte address
- mem_reg2  in  DW  store data
- mem_wd  in  AW  destination register
- mem_wreg  in  1  write enable
- mem_wdata  in  DW  ALU result (used for non-memory ops)
- stall_in  in  1  pipeline controller is holding the MEM stage this cycle
- flush  in  1  discard the current instruction
- dbus_req  out  1  bus request
- dbus_we  out  1  1=write
- dbus_addr  out  DW  word address; bits [1:0] are always 0
- dbus_sel  out  4  byte lanes; bit3 = bits [31:24]
- dbus_wdata  out  DW  write data
- dbus_ack  in  1  transaction complete; read data valid in the same cycle
- dbus_rdata  in  DW  read data
- stallreq  out  1  request to stall the pipeline
- wb_wd  out  AW  to MEM/WB
- wb_wreg  out  1  to MEM/WB
- wb_wdata  out  DW  to MEM/WB

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - While rst=1, all outputs are 0 and the state is IDLE.
  - A reset mid-transaction drops dbus_req at the next edge; any later ack is ignored.
- States: IDLE, BUSY, HOLD. dbus_* outputs are registered.
- IDLE:
  - If a memory op is present and flush=0: stallreq=1 (combinational). At the clock edge, load the bus registers, set dbus_req=1, and go to BUSY.
  - If a non-memory op is present: stallreq=0, wb_* = mem_wd / mem_wreg / mem_wdata, and there is no bus activity.
- BUSY:
  - Bus outputs are held stable; stallreq = !dbus_ack.
  - On dbus_ack, in the same cycle: stallreq=0 and wb_wdata = formatted dbus_rdata (loads) or mem_wdata (stores).
  - At the ack edge: dbus_req←0, buffer←formatted data. Next state is HOLD if stall_in=1, else IDLE.
- HOLD:
  - The bus is idle and stallreq=0; wb_wdata comes from the buffer.
  - Return to IDLE at the first edge with stall_in=0.
  - This prevents re-issuing the same instruction while the pipeline is stalled for another reason.
- Write-back controls: wb_wd and wb_wreg always follow the inputs. They are also forced to 0 when flush=1.
- Byte lanes, with a = mem_addr[1:0]:
  - Byte ops: a=0→1000, 1→0100, 2→0010, 3→0001.
  - Halfword ops: a[1]=0→1100, a[1]=1→0011.
  - Word ops: 1111.
  - Misalignment raises no exception; sel is derived from a only (a[0] is ignored for halfwords and a is ignored for words).
- Store data:
  - SB replicates reg2[7:0] into all four bytes.
  - SH replicates reg2[15:0] into both halves.
  - SW uses reg2 unchanged.
  - dbus_we=1 for stores only.
- Load formatting: the byte or half is taken from the selected lane. LB/LH sign-extend, LBU/LHU zero-extend, LW uses the word unchanged.
- Flush:
  - In any state, flush=1 forces the next state to IDLE and dbus_req←0.
  - stallreq=0 in the flush cycle.
  - An ack arriving in the flush cycle is ignored.
- Ack arriving with dbus_req=0 (in IDLE or HOLD): ignored.
- Minimum memory-op latency: instruction arrives in cycle N (stall asserted); req is high from N+1; with ack in N+1, the result is valid in N+1 and stallreq=0 in N+1.

Test Plan:
- LW at addr 0x100, rdata 0xDEADBEEF, ack after 3 wait cycles:
  - dbus_addr=0x100, sel=1111, we=0.
  - stallreq=1 for 4 cycles (issue cycle plus 3 wait cycles).
  - wb_wdata=0xDEADBEEF in the ack cycle; req=0 on the next cycle.
- LB/LBU at addr 0x103 with rdata 0x123456F0:
  - sel=0001.
  - LB → 0xFFFFFFF0; LBU → 0x000000F0.
  - LH at 0x102 with rdata 0x1234_8001 → sel=0011, wb_wdata=0xFFFF8001.
- SB at 0x201 with reg2=0xAABBCCDD:
  - dbus_addr=0x200, sel=0100, wdata=0xDDDDDDDD, we=1.
  - SH at 0x202 → sel=0011, wdata=0xCCDDCCDD.
- LW acked while stall_in=1 held for 3 more cycles:
  - State goes to HOLD; no second req.
  - wb_wdata holds the buffered value.
  - Next cycle after stall_in falls: IDLE; the following instruction issues normally.
- flush asserted in the 2nd BUSY cycle:
  - req=0 next cycle and stallreq=0 immediately.
  - A late ack causes no state change.
  - Also: rst mid-BUSY → all outputs 0 the next cycle.
- Non-memory op (aluop 8'h25) with wdata=0x5:
  - stallreq=0, no req, wb_wdata=0x5 in the same cycle.
